// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are held for an op-dependent number of cycles; results return on per-requester channels.
module alu_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_sel,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_c,
  output logic             rsp0_z,
  output logic             rsp0_n,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_c,
  output logic             rsp1_z,
  output logic             rsp1_n,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_z,
  input  logic             alu_n
);

  localparam int unsigned MAX_L = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W = (MAX_L < 2) ? 1 : $clog2(MAX_L + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [2:0]         alu_sel_q, alu_sel_d;
  logic               rsp0_valid_q, rsp0_valid_d;
  logic [WIDTH-1:0]   rsp0_c_q, rsp0_c_d;
  logic               rsp0_z_q, rsp0_z_d;
  logic               rsp0_n_q, rsp0_n_d;
  logic               rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0]   rsp1_c_q, rsp1_c_d;
  logic               rsp1_z_q, rsp1_z_d;
  logic               rsp1_n_q, rsp1_n_d;

  logic               grant;
  logic               any_req;
  logic [2:0]         grant_sel;

  function automatic logic [CNT_W-1:0] exec_len(input logic [2:0] sel);
    case (sel)
      3'b010:  exec_len = CNT_W'(MUL_CYCLES);
      3'b011:  exec_len = CNT_W'(DIV_CYCLES);
      default: exec_len = CNT_W'(1);
    endcase
  endfunction

  // On a tie, the requester not granted last time wins.
  always_comb begin
    any_req   = req0_valid | req1_valid;
    grant     = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    grant_sel = grant ? req1_sel : req0_sel;
    req0_ready = (state_q == S_IDLE) & req0_valid & ~grant;
    req1_ready = (state_q == S_IDLE) & req1_valid & grant;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp0_c_d     = rsp0_c_q;
    rsp0_z_d     = rsp0_z_q;
    rsp0_n_d     = rsp0_n_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_c_d     = rsp1_c_q;
    rsp1_z_d     = rsp1_z_q;
    rsp1_n_d     = rsp1_n_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          alu_a_d      = grant ? req1_a : req0_a;
          alu_b_d      = grant ? req1_b : req0_b;
          alu_sel_d    = grant_sel;
          owner_d      = grant;
          last_grant_d = grant;
          cnt_d        = exec_len(grant_sel);
          state_d      = S_EXEC;
        end
      end

      S_EXEC: begin
        // A zero count can only follow a bad parameter; treat it as the final cycle.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d = '0;
          if (owner_q) begin
            rsp1_c_d     = alu_c;
            rsp1_z_d     = alu_z;
            rsp1_n_d     = alu_n;
            rsp1_valid_d = 1'b1;
          end else begin
            rsp0_c_d     = alu_c;
            rsp0_z_d     = alu_z;
            rsp0_n_d     = alu_n;
            rsp0_valid_d = 1'b1;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RESP: begin
        if (owner_q) begin
          if (rsp1_ready) begin
            rsp1_valid_d = 1'b0;
            state_d      = S_IDLE;
          end
        end else begin
          if (rsp0_ready) begin
            rsp0_valid_d = 1'b0;
            state_d      = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_c_q     <= '0;
      rsp0_z_q     <= 1'b0;
      rsp0_n_q     <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_c_q     <= '0;
      rsp1_z_q     <= 1'b0;
      rsp1_n_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_c_q     <= rsp0_c_d;
      rsp0_z_q     <= rsp0_z_d;
      rsp0_n_q     <= rsp0_n_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_c_q     <= rsp1_c_d;
      rsp1_z_q     <= rsp1_z_d;
      rsp1_n_q     <= rsp1_n_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_c     = rsp0_c_q;
  assign rsp0_z     = rsp0_z_q;
  assign rsp0_n     = rsp0_n_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_c     = rsp1_c_q;
  assign rsp1_z     = rsp1_z_q;
  assign rsp1_n     = rsp1_n_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single combinational `alu` (ops: add, sub, mul, div, asr, lsr, and) between two requesters in the pipeline project. Requesters present operands and an op select over valid/ready handshakes. The block grants round-robin, holds the ALU inputs stable for an op-dependent number of cycles so the long mul/div paths settle, registers result and flags, and returns them on a per-requester valid/ready response channel. One operation is in flight at a time.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width
- `MUL_CYCLES`, 2, EXEC cycles for sel 010 (≥1)
- `DIV_CYCLES`, 4, EXEC cycles for sel 011 (≥1)

Ports (N ∈ {0,1}). One clock; reset is synchronous and active-high.
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous active-high reset
- `reqN_valid`  in  1  requester N has an op
- `reqN_ready`  out  1  arbiter accepts requester N's op this cycle
- `reqN_a`, `reqN_b`  in  WIDTH  operands
- `reqN_sel`  in  3  ALU op select
- `rspN_valid`  out  1  result for requester N available
- `rspN_ready`  in  1  requester N takes result
- `rspN_c`  out  WIDTH  result
- `rspN_z`, `rspN_n`  out  1  zero / negative flags
- `alu_a`, `alu_b`  out  WIDTH  to ALU A/B
- `alu_sel`  out  3  to ALU sel
- `alu_c`  in  WIDTH  from ALU C
- `alu_z`, `alu_n`  in  1  from ALU flagZ/flagN

## Operation
- FSM states: IDLE, EXEC, RESP. Internal: `owner` (1 bit), `last_grant` (1 bit), cycle counter, operand/result registers.
- IDLE:
  - If exactly one `reqN_valid` is high, grant N.
  - If both are high, grant `!last_grant`.
  - `reqN_ready` = (state==IDLE) & granted N, combinational. Only one ready is ever high.
  - On handshake: latch a/b/sel into `alu_a/alu_b/alu_sel`, set `owner`=`last_grant`=N, load counter with L, go to EXEC.
- L per sel: 010 → MUL_CYCLES, 011 → DIV_CYCLES, all others (incl. undefined 111) → 1.
- EXEC:
  - ALU outputs held constant.
  - Counter decrements each cycle. In the cycle where it reads 1, capture `alu_c/z/n` into `rsp{owner}` data regs and go to RESP.
- RESP:
  - `rsp{owner}_valid`=1; the other rsp valid stays 0.
  - When `rsp{owner}_ready`=1, drop valid and go to IDLE.
  - No new request is accepted in the cycle of the response handshake.
- Requesters keep valid high with a stable payload until accepted. The block does not handle requests that are withdrawn before acceptance.
- `rspN_c/z/n` hold their last value after valid drops. `alu_*` hold their last operands in IDLE/RESP.
- Div-by-zero and undefined sel: results pass through from the ALU unchanged. No error signalling.

## Timing
- Handshake in cycle t. EXEC occupies cycles t+1…t+L. Result is registered at the end of t+L. `rspN_valid` rises in cycle t+L+1.
- Add: `rsp_valid` at t+2. Mul (default): t+3. Div (default): t+5.
- Minimum spacing between acceptances with `rsp_ready` held high: L+2 cycles.
- Backpressure: while `rspN_valid & !rspN_ready`, the FSM stays in RESP and c/z/n are stable. All `reqN_ready` stay 0.
- Reset values:
  - state=IDLE, `last_grant`=1 (req0 wins the first tie), counter=0.
  - All `reqN_ready`/`rspN_valid` = 0.
  - `rspN_c`=0, `rspN_z`=0, `rspN_n`=0.
  - `alu_a`=`alu_b`=0, `alu_sel`=000.
- Reset mid-EXEC or mid-RESP discards the op. No response is ever issued for it.
- A request arriving during EXEC/RESP waits; its ready first rises in the IDLE cycle after the response handshake.

## Test plan
- Single add: req0 a=0x0000000A, b=0x00000005, sel=000 accepted at t. Required: `rsp0_valid` at t+2 with c=0x0000000F, z=0, n=0; `rsp1_valid` stays 0.
- Sub flags: req1 a=5, b=0xA, sel=001 → c=0xFFFFFFFB, n=1, z=0. Then a=7, b=7, sel=001 → c=0, z=1, n=0.
- Multi-cycle, both requesters valid from reset:
  - Ops: req0 mul 0xA×3, req1 div 0xF/3.
  - req0 granted first; `alu_*` stable for 2 cycles; `rsp0_c`=0x1E at t+3.
  - req1 granted in the next IDLE; `rsp1_c`=0x5 exactly 5 cycles after its handshake.
- Round-robin: both requesters hold valid with `rsp_ready`=1 for 4 ops (sel=110, a=0xF, b=5). Required: grant order 0,1,0,1, each c=0x5, spacing 3 cycles.
- Backpressure: `rsp0_ready`=0 for 5 cycles after `rsp0_valid` rises while req1 is valid. Required: `rsp0_valid`/c stable, `req1_ready`=0 throughout; req1 accepted the cycle after the IDLE return.
- Reset mid-op: assert `rst` in the second EXEC cycle of a div. Required: no rsp valid, all outputs at reset values next cycle. A following simultaneous req0/req1 grants req0.
